logic_sweep_unit: RTL and testbench



---
 rtl/logic_sweep_unit.sv | 119 +++++++++++
 tb/tb_logic_sweep_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_sweep_unit.sv
// Registered bitwise evaluator of S = (a | b&c) & ((a | c) & b), with a direct mode
// and a self-timed exhaustive sweep that counts the non-zero results as a checksum.
module logic_sweep_unit #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     c,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     result,
    output logic [3*WIDTH-1:0]   vec,
    output logic [3*WIDTH:0]     ones_count,
    output logic                 busy,
    output logic                 done
);

    localparam int VEC_W = 3 * WIDTH;
    localparam int CNT_W = 3 * WIDTH + 1;
    localparam logic [VEC_W-1:0] IDX_LAST = {VEC_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [VEC_W-1:0] idx, idx_nxt;
    logic             out_valid_nxt;
    logic [WIDTH-1:0] result_nxt;
    logic [VEC_W-1:0] vec_nxt;
    logic [CNT_W-1:0] ones_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic [WIDTH-1:0] sweep_res;

    function automatic logic [WIDTH-1:0] s_func(input logic [WIDTH-1:0] fa,
                                                input logic [WIDTH-1:0] fb,
                                                input logic [WIDTH-1:0] fc);
        return (fa | (fb & fc)) & ((fa | fc) & fb);
    endfunction

    // The sweep index is split into {a,b,c} fields with a in the most significant slot.
    assign sweep_res = s_func(idx[VEC_W-1 -: WIDTH], idx[2*WIDTH-1 -: WIDTH], idx[WIDTH-1:0]);

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        out_valid_nxt = 1'b0;
        result_nxt    = result;
        vec_nxt       = vec;
        ones_nxt      = ones_count;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SWEEP;
                    idx_nxt   = '0;
                    ones_nxt  = '0;
                    busy_nxt  = 1'b1;
                end else if (in_valid) begin
                    result_nxt    = s_func(a, b, c);
                    vec_nxt       = {a, b, c};
                    out_valid_nxt = 1'b1;
                end
            end
            SWEEP: begin
                result_nxt    = sweep_res;
                vec_nxt       = idx;
                out_valid_nxt = 1'b1;
                ones_nxt      = ones_count + CNT_W'(|sweep_res);
                // Terminal vector is detected explicitly rather than relying on idx wrapping.
                if (idx == IDX_LAST) begin
                    state_nxt = DONE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + VEC_W'(1);
                end
            end
            DONE: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            out_valid  <= 1'b0;
            result     <= '0;
            vec        <= '0;
            ones_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            out_valid  <= out_valid_nxt;
            result     <= result_nxt;
            vec        <= vec_nxt;
            ones_count <= ones_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_logic_sweep_unit.sv
// Self-checking bench for logic_sweep_unit: a WIDTH=1 and a WIDTH=2 instance checked
// against a truth-table reference model and closed-form sweep checksums.
module tb_logic_sweep_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, in_valid;
    logic [0:0] a, b, c;
    logic       out_valid, busy, done;
    logic [0:0] result;
    logic [2:0] vec;
    logic [3:0] ones_count;

    logic       start2, in_valid2;
    logic [1:0] a2, b2, c2;
    logic       out_valid2, busy2, done2;
    logic [1:0] result2;
    logic [5:0] vec2;
    logic [6:0] ones_count2;

    int checks = 0;
    int errors = 0;
    int running;
    int exp_r;

    // Single-bit truth table of S indexed by {a,b,c}
    int tt [8] = '{0, 0, 0, 1, 0, 0, 1, 1};

    always #5 clk = ~clk;

    logic_sweep_unit #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .out_valid(out_valid), .result(result), .vec(vec),
        .ones_count(ones_count), .busy(busy), .done(done)
    );

    logic_sweep_unit #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid2),
        .a(a2), .b(b2), .c(c2), .out_valid(out_valid2), .result(result2), .vec(vec2),
        .ones_count(ones_count2), .busy(busy2), .done(done2)
    );

    function automatic int model_s(input int w, input int av, input int bv, input int cv);
        int r = 0;
        for (int i = 0; i < w; i++)
            r += tt[((av >> i) & 1) * 4 + ((bv >> i) & 1) * 2 + ((cv >> i) & 1)] << i;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit st, input bit iv, input int av, input int bv, input int cv);
        start    = st;
        in_valid = iv;
        a        = av[0:0];
        b        = bv[0:0];
        c        = cv[0:0];
    endtask

    // Full WIDTH=1 sweep; optionally with a simultaneous in_valid and random noise mid-sweep
    task automatic run_sweep1(input bit with_iv, input bit noise);
        applyStimulus(1'b1, with_iv, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        tick();
        applyStimulus(1'b0, 1'b0, 0, 0, 0);
        checkOutput("e0_busy", busy, 1);
        checkOutput("e0_valid", out_valid, 0);
        running = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_r = model_s(1, (k >> 2) & 1, (k >> 1) & 1, k & 1);
            if (exp_r != 0) running++;
            checkOutput("sw_valid", out_valid, 1);
            checkOutput("sw_vec", vec, k);
            checkOutput("sw_result", result, exp_r);
            checkOutput("sw_ones", ones_count, running);
            checkOutput("sw_busy", busy, 1);
            checkOutput("sw_done", done, 0);
            if (noise && k < 7)
                applyStimulus($urandom_range(0, 1), $urandom_range(0, 1),
                              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            else
                applyStimulus(1'b0, 1'b0, 0, 0, 0);
        end
        tick();
        checkOutput("end_valid", out_valid, 0);
        checkOutput("end_done", done, 1);
        checkOutput("end_busy", busy, 0);
        checkOutput("end_ones", ones_count, 8 - 5);
        tick();
        checkOutput("post_done", done, 0);
        checkOutput("post_ones", ones_count, 8 - 5);
    endtask

    // Back-to-back direct requests; in_valid occasionally low when rnd_gaps is set
    task automatic run_direct(input int n, input bit fixed, input int hold_ones);
        int av, bv, cv, iv;
        int fa [3] = '{1, 0, 0};
        int fb [3] = '{1, 1, 0};
        int fc [3] = '{0, 1, 1};
        for (int j = 0; j < n; j++) begin
            if (fixed) begin
                av = fa[j]; bv = fb[j]; cv = fc[j]; iv = 1;
            end else begin
                av = $urandom_range(0, 1); bv = $urandom_range(0, 1); cv = $urandom_range(0, 1);
                iv = ($urandom_range(0, 3) != 0) ? 1 : 0;
            end
            applyStimulus(1'b0, iv[0], av, bv, cv);
            tick();
            checkOutput("dir_valid", out_valid, iv);
            if (iv != 0) begin
                checkOutput("dir_result", result, model_s(1, av, bv, cv));
                checkOutput("dir_vec", vec, av * 4 + bv * 2 + cv);
            end
            checkOutput("dir_ones", ones_count, hold_ones);
        end
        applyStimulus(1'b0, 1'b0, 0, 0, 0);
        tick();
        checkOutput("dir_idle", out_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 0, 0, 0);
        start2 = 1'b0; in_valid2 = 1'b0; a2 = '0; b2 = '0; c2 = '0;
        #1;
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_vec", vec, 0);
        checkOutput("rst_ones", ones_count, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] direct fixed vectors");
        run_direct(3, 1'b1, 0);

        $display("[TB] WIDTH=1 sweep");
        run_sweep1(1'b0, 1'b0);

        $display("[TB] direct random vectors");
        run_direct(24, 1'b0, 3);

        $display("[TB] start with in_valid, noise mid-sweep");
        run_sweep1(1'b1, 1'b1);

        $display("[TB] reset mid-sweep");
        applyStimulus(1'b1, 1'b0, 0, 0, 0);
        tick();
        applyStimulus(1'b0, 1'b0, 0, 0, 0);
        for (int k = 0; k < 5; k++) tick();
        checkOutput("abort_vec_before", vec, 4);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_valid", out_valid, 0);
        checkOutput("abort_result", result, 0);
        checkOutput("abort_vec", vec, 0);
        checkOutput("abort_ones", ones_count, 0);
        checkOutput("abort_busy", busy, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("abort_done", done, 0);
        end
        rst_n = 1'b1;
        tick();
        checkOutput("rel_busy", busy, 0);
        checkOutput("rel_done", done, 0);
        run_sweep1(1'b0, 1'b0);

        $display("[TB] start held high for 20 edges");
        start = 1'b1;
        tick();
        for (int n = 1; n <= 21; n++) begin
            if (n == 20) start = 1'b0;
            tick();
            checkOutput("hold_valid", out_valid, ((n >= 1 && n <= 8) || (n >= 11 && n <= 18)) ? 1 : 0);
            checkOutput("hold_done", done, (n == 9 || n == 19) ? 1 : 0);
            checkOutput("hold_busy", busy, ((n <= 8) || (n >= 10 && n <= 18)) ? 1 : 0);
            if (n >= 1 && n <= 8)   checkOutput("hold_vec1", vec, n - 1);
            if (n >= 11 && n <= 18) checkOutput("hold_vec2", vec, n - 11);
            if (n == 8 || n == 18)  checkOutput("hold_ones_final", ones_count, 3);
            if (n == 10)            checkOutput("hold_ones_restart", ones_count, 0);
        end

        $display("[TB] WIDTH=2 sweep");
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        checkOutput("w2_busy_e0", busy2, 1);
        running = 0;
        for (int k = 0; k < 64; k++) begin
            tick();
            exp_r = model_s(2, (k >> 4) & 3, (k >> 2) & 3, k & 3);
            if (exp_r != 0) running++;
            checkOutput("w2_valid", out_valid2, 1);
            checkOutput("w2_vec", vec2, k);
            checkOutput("w2_result", result2, exp_r);
            checkOutput("w2_ones", ones_count2, running);
        end
        tick();
        checkOutput("w2_done", done2, 1);
        checkOutput("w2_busy", busy2, 0);
        checkOutput("w2_valid_end", out_valid2, 0);
        checkOutput("w2_ones_final", ones_count2, 64 - 25);
        tick();
        checkOutput("w2_done_clear", done2, 0);
        checkOutput("w2_ones_hold", ones_count2, 64 - 25);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
